fir_seq_ctrl: RTL and testbench

- Controller that sequences the FIR filter datapath.
- Holds off the FIR's post-reset setup window, then accepts host commands:
  - writes coefficients into a shadow bank;
  - commits the bank by shifting it into the FIR through its config path;
  - gates the sample stream into the FIR.
- Sits between the host/pin-level interface and the FIR's x_n / s_axis_fir_tvalid / s_set_coeffs inputs.
- Serialises FIR access, so config and streaming never overlap.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_coeff_bank.sv | 32 +++
 rtl/fir_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, opcodes and controller states for the FIR sequencer
package fir_pkg;

    localparam int TAP_SIZE_DEF     = 3;
    localparam int NBR_OF_TAPS_DEF  = 6;
    localparam int X_N_SIZE_DEF     = 8;
    localparam int SETUP_CYCLES_DEF = 4;

    localparam logic [1:0] OP_WRITE_COEF = 2'd0;
    localparam logic [1:0] OP_COMMIT     = 2'd1;
    localparam logic [1:0] OP_START      = 2'd2;
    localparam logic [1:0] OP_STOP       = 2'd3;

    typedef enum logic [2:0] {
        WAIT_SETUP,
        IDLE,
        LOAD,
        GAP,
        STREAM
    } fir_state_e;

    // Index width for a table of the given depth, never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - shadow coefficient register file, one write port and one async read port
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int TAP_SIZE    = TAP_SIZE_DEF,
    parameter int NBR_OF_TAPS = NBR_OF_TAPS_DEF,
    localparam int PTR_W      = ptr_width(NBR_OF_TAPS)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                wr_en_i,
    input  logic [PTR_W-1:0]    wr_addr_i,
    input  logic [TAP_SIZE-1:0] wr_data_i,
    input  logic [PTR_W-1:0]    rd_addr_i,
    output logic [TAP_SIZE-1:0] rd_data_o
);

    logic [TAP_SIZE-1:0] mem_q [NBR_OF_TAPS];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NBR_OF_TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - sequences FIR setup holdoff, coefficient loading and sample streaming
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int TAP_SIZE     = TAP_SIZE_DEF,
    parameter int NBR_OF_TAPS  = NBR_OF_TAPS_DEF,
    parameter int X_N_SIZE     = X_N_SIZE_DEF,
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    localparam int PTR_W       = ptr_width(NBR_OF_TAPS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [TAP_SIZE-1:0] cmd_data,
    input  logic                s_valid,
    input  logic [X_N_SIZE-1:0] s_data,
    output logic                s_ready,
    output logic [X_N_SIZE-1:0] fir_x_n,
    output logic                fir_tvalid,
    output logic                fir_set_coeffs,
    output logic                busy,
    output logic                coeffs_dirty,
    output logic [PTR_W-1:0]    wr_ptr
);

    localparam int CNT_W = ptr_width(SETUP_CYCLES + 1);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NBR_OF_TAPS - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

    fir_state_e          state_q;
    logic [CNT_W-1:0]    setup_cnt_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    load_idx_q;
    logic                coeffs_dirty_q;
    logic [X_N_SIZE-1:0] fir_x_n_q;
    logic                fir_tvalid_q;
    logic                fir_set_coeffs_q;
    logic                cmd_ready_q;
    logic                s_ready_q;
    logic                busy_q;

    logic                cmd_fire;
    logic                coef_we;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    load_idx_d;
    logic [TAP_SIZE-1:0] bank_rd_data;

    assign cmd_fire = cmd_valid && cmd_ready_q;
    assign coef_we  = cmd_fire && (cmd_op == OP_WRITE_COEF);
    assign wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;

    // The bank is read one index ahead so fir_x_n can be registered on the same edge.
    assign load_idx_d = (state_q == LOAD) ? load_idx_q - 1'b1 : LAST_IDX;

    fir_coeff_bank #(
        .TAP_SIZE    (TAP_SIZE),
        .NBR_OF_TAPS (NBR_OF_TAPS)
    ) u_bank (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (coef_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (cmd_data),
        .rd_addr_i (load_idx_d),
        .rd_data_o (bank_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= WAIT_SETUP;
            setup_cnt_q      <= '0;
            wr_ptr_q         <= '0;
            load_idx_q       <= '0;
            coeffs_dirty_q   <= 1'b0;
            fir_x_n_q        <= '0;
            fir_tvalid_q     <= 1'b0;
            fir_set_coeffs_q <= 1'b0;
            cmd_ready_q      <= 1'b0;
            s_ready_q        <= 1'b0;
            busy_q           <= 1'b1;
        end else begin
            if (coef_we) begin
                wr_ptr_q       <= wr_ptr_d;
                coeffs_dirty_q <= 1'b1;
            end

            case (state_q)
                WAIT_SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end

                // COMMIT and STOP win over a sample offered in the same cycle.
                IDLE, STREAM: begin
                    fir_tvalid_q <= 1'b0;
                    if (cmd_fire && cmd_op == OP_COMMIT) begin
                        state_q          <= LOAD;
                        load_idx_q       <= LAST_IDX;
                        fir_x_n_q        <= X_N_SIZE'(bank_rd_data);
                        fir_set_coeffs_q <= 1'b1;
                        cmd_ready_q      <= 1'b0;
                        s_ready_q        <= 1'b0;
                        busy_q           <= 1'b1;
                    end else if (cmd_fire && cmd_op == OP_STOP) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b0;
                    end else begin
                        if (cmd_fire && cmd_op == OP_START) begin
                            state_q   <= STREAM;
                            s_ready_q <= 1'b1;
                        end
                        if (s_valid && s_ready_q) begin
                            fir_x_n_q    <= s_data;
                            fir_tvalid_q <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (load_idx_q == '0) begin
                        state_q          <= GAP;
                        fir_set_coeffs_q <= 1'b0;
                        fir_x_n_q        <= '0;
                    end else begin
                        load_idx_q <= load_idx_d;
                        fir_x_n_q  <= X_N_SIZE'(bank_rd_data);
                    end
                end

                GAP: begin
                    state_q        <= IDLE;
                    cmd_ready_q    <= 1'b1;
                    busy_q         <= 1'b0;
                    coeffs_dirty_q <= 1'b0;
                    wr_ptr_q       <= '0;
                end

                default: state_q <= WAIT_SETUP;
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign s_ready        = s_ready_q;
    assign fir_x_n        = fir_x_n_q;
    assign fir_tvalid     = fir_tvalid_q;
    assign fir_set_coeffs = fir_set_coeffs_q;
    assign busy           = busy_q;
    assign coeffs_dirty   = coeffs_dirty_q;
    assign wr_ptr         = wr_ptr_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed and randomized bench for fir_seq_ctrl against a schedule-queue model
module tb_fir_seq_ctrl;

    localparam int NT = 6;
    localparam int TS = 3;
    localparam int XW = 8;
    localparam int SC = 4;
    localparam int PW = 3;

    localparam int C_WRITE  = 0;
    localparam int C_COMMIT = 1;
    localparam int C_START  = 2;
    localparam int C_STOP   = 3;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = '0;
    logic [TS-1:0] cmd_data  = '0;
    logic          s_valid   = 1'b0;
    logic [XW-1:0] s_data    = '0;
    logic          cmd_ready;
    logic          s_ready;
    logic [XW-1:0] fir_x_n;
    logic          fir_tvalid;
    logic          fir_set_coeffs;
    logic          busy;
    logic          coeffs_dirty;
    logic [PW-1:0] wr_ptr;

    always #5 clk = ~clk;

    fir_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .fir_x_n        (fir_x_n),
        .fir_tvalid     (fir_tvalid),
        .fir_set_coeffs (fir_set_coeffs),
        .busy           (busy),
        .coeffs_dirty   (coeffs_dirty),
        .wr_ptr         (wr_ptr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model: remaining setup cycles, a queue of upcoming config cycles
    // (coefficient value, or -1 for the gap), and the host-visible bank state.
    int m_bank [NT];
    int m_wp;
    int m_setup;
    int m_x;
    bit m_dirty;
    bit m_stream;
    bit m_tv;
    int m_load [$];

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) m_bank[i] = 0;
        m_wp     = 0;
        m_setup  = SC;
        m_x      = 0;
        m_dirty  = 1'b0;
        m_stream = 1'b0;
        m_tv     = 1'b0;
        m_load.delete();
    endfunction

    task automatic step(input bit cv, input int op, input int cd, input bit sv, input int sd);
        bit e_busy, e_crdy, e_srdy, e_set, cfire, sfire;
        int e_x, v;
        e_busy = (m_setup > 0) || (m_load.size() > 0);
        e_crdy = !e_busy;
        e_srdy = e_crdy && m_stream;
        e_set  = (m_load.size() > 0) && (m_load[0] >= 0);
        e_x    = (m_load.size() > 0) ? (e_set ? m_load[0] : 0) : m_x;
        check("busy", busy, e_busy);
        check("cmd_ready", cmd_ready, e_crdy);
        check("s_ready", s_ready, e_srdy);
        check("fir_set_coeffs", fir_set_coeffs, e_set);
        check("fir_tvalid", fir_tvalid, m_tv);
        check("fir_x_n", fir_x_n, e_x);
        check("coeffs_dirty", coeffs_dirty, m_dirty);
        check("wr_ptr", wr_ptr, m_wp);
        check("strobe_exclusive", fir_tvalid && fir_set_coeffs, 0);

        cmd_valid = cv;
        cmd_op    = 2'(op);
        cmd_data  = TS'(cd);
        s_valid   = sv;
        s_data    = XW'(sd);

        m_tv = 1'b0;
        if (m_setup > 0) m_setup--;
        if (m_load.size() > 0) begin
            v = m_load.pop_front();
            if (v < 0) begin
                m_x     = 0;
                m_dirty = 1'b0;
                m_wp    = 0;
            end else begin
                m_x = v;
            end
        end

        cfire = cv && e_crdy;
        sfire = sv && e_srdy;
        if (cfire) begin
            case (op)
                C_WRITE: begin
                    m_bank[m_wp] = cd & ((1 << TS) - 1);
                    m_wp         = (m_wp + 1) % NT;
                    m_dirty      = 1'b1;
                end
                C_COMMIT: begin
                    for (int i = NT - 1; i >= 0; i--) m_load.push_back(m_bank[i]);
                    m_load.push_back(-1);
                    m_stream = 1'b0;
                end
                C_START: m_stream = 1'b1;
                default: m_stream = 1'b0;
            endcase
        end
        if (sfire && !(cfire && (op == C_COMMIT || op == C_STOP))) begin
            m_tv = 1'b1;
            m_x  = sd & ((1 << XW) - 1);
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, C_WRITE, 0, 1'b0, 0);
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Setup holdoff: COMMIT held from the first cycle is only taken on cycle 5.
        repeat (SC + 1) step(1'b1, C_COMMIT, 0, 1'b0, 0);
        idle(NT + 2);

        // Load order 1..6 emitted last-first.
        for (int i = 1; i <= NT; i++) step(1'b1, C_WRITE, i, 1'b0, 0);
        step(1'b1, C_COMMIT, 0, 1'b0, 0);
        idle(NT + 2);

        // Streaming with latency 1 and a held value on the idle cycle.
        step(1'b1, C_START, 0, 1'b0, 0);
        step(1'b0, C_WRITE, 0, 1'b1, 8'h10);
        step(1'b0, C_WRITE, 0, 1'b1, 8'h80);
        step(1'b0, C_WRITE, 0, 1'b0, 0);
        step(1'b0, C_WRITE, 0, 1'b1, 8'h7F);
        step(1'b1, C_WRITE, 5, 1'b1, 8'h22);
        idle(2);

        // COMMIT beats a sample in the same cycle.
        step(1'b1, C_COMMIT, 0, 1'b1, 8'h55);
        idle(NT + 2);

        // Wrap-around: eight writes overwrite indices 0 and 1.
        for (int i = 1; i <= 8; i++) step(1'b1, C_WRITE, i, 1'b0, 0);
        step(1'b1, C_COMMIT, 0, 1'b0, 0);
        idle(NT + 2);

        // Reset in the third load cycle, then prove the bank was cleared.
        for (int i = 1; i <= 3; i++) step(1'b1, C_WRITE, i + 3, 1'b0, 0);
        step(1'b1, C_COMMIT, 0, 1'b0, 0);
        idle(2);
        pulse_reset();
        idle(SC + 1);
        step(1'b1, C_COMMIT, 0, 1'b0, 0);
        idle(NT + 2);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            int r, op;
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                r  = $urandom_range(0, 7);
                op = (r < 4) ? C_WRITE : (r == 4) ? C_COMMIT : (r < 7) ? C_START : C_STOP;
                step($urandom_range(0, 9) < 4, op, $urandom_range(0, 7),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 255));
            end
        end
        idle(NT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
